sync_fifo_16x8_ctrl: RTL
========================

Name: sync_fifo_16x8_ctrl

Overview:
Synchronous FIFO controller that sits directly upstream of the team's 16x8 synchronous dual-port RAM and owns its control ports. It converts a push/pop client interface into RAM write and read strobes and addresses. It generates full, empty, almost-full and almost-empty flags, a fill count and sticky error flags. Read data comes back from the RAM's registered output and is qualified by pop_valid.

Parameters:
DATA_WIDTH, 8, data word width; must match the RAM width
DEPTH, 16, number of entries; must equal 2**ADDR_SIZE
ADDR_SIZE, 4, RAM address width
AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
push  input  1  write request
push_data  input  DATA_WIDTH  write data
pop  input  1  read request
pop_data  output  DATA_WIDTH  read data, combinational pass-through of ram_d_out
pop_valid  output  1  pop_data valid this cycle
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  ADDR_SIZE+1  current fill level, 0..DEPTH
overflow  output  1  sticky: push was rejected
underflow  output  1  sticky: pop was rejected
ram_wr_en  output  1  RAM write strobe
ram_wr_addr  output  ADDR_SIZE  RAM write address
ram_d_in  output  DATA_WIDTH  RAM write data (= push_data)
ram_rd_en  output  1  RAM read strobe
ram_rd_addr  output  ADDR_SIZE  RAM read address
ram_d_out  input  DATA_WIDTH  RAM registered read data

Behaviour:
- Reset: reset is synchronous and active-high; the clock is clock. On reset: wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, overflow=0, underflow=0. Flags after reset: empty=1, full=0, almost_empty=1, almost_full=0. Reset overrides push and pop in the same cycle.
- Pointers: wr_ptr and rd_ptr are each ADDR_SIZE+1 bits; the MSB is a wrap bit. RAM addresses are ptr[ADDR_SIZE-1:0]. Pointers wrap naturally from 31 to 0.
- empty = (wr_ptr == rd_ptr).
- full = (MSBs differ) and (low bits equal).
- All flags and count decode from registered state only; there is no combinational path from push or pop to any flag.
- Acceptance rules:
  - pop_acc = pop & ~empty.
  - push_acc = push & (~full | pop_acc).
- Outputs: ram_wr_en = push_acc; ram_rd_en = pop_acc. Both are combinational.
- Pointer and count updates:
  - wr_ptr increments on push_acc.
  - rd_ptr increments on pop_acc.
  - count increments on push_acc only, decrements on pop_acc only, and is unchanged when both or neither occur.
- Read latency: 1 cycle. pop_valid is a register loaded with pop_acc. pop_data is ram_d_out, valid while pop_valid=1.
- Full with push and pop in the same cycle: both are accepted. The write and read target the same address; the RAM returns the old word. Count stays at DEPTH.
- Empty with push and pop in the same cycle: the push is accepted and the pop is rejected; underflow is set.
- Push while full without pop: the push is dropped and overflow is set. Pointers are unchanged.
- Pop while empty: ram_rd_en=0 and underflow is set.
- Error flags: overflow and underflow are sticky until reset.
- Reset mid-operation: any in-flight read is discarded (pop_valid=0 the next cycle). RAM contents are not relied upon after reset.
- Invariant: count == wr_ptr - rd_ptr (mod 2*DEPTH) at all times.

Decomposition:
- Shared package fifo_pkg holds DATA_WIDTH, ADDR_SIZE and DEPTH constants, the default AF_LEVEL and AE_LEVEL, and a ptr_t typedef (ADDR_SIZE+1 bits).
- One sub-module, fifo_ptr: a wrap-bit pointer register with an increment enable and synchronous reset. It is instantiated twice, once for write and once for read.
- The RAM remains an external instance, connected through the ram_* ports.

Test Plan:
- Reset, then push 16 words 0x10..0x1F -> ram_wr_addr steps 0..15. After the 16th push: full=1, count=16, almost_full has been set since count=14, overflow=0.
- 17th push while full -> ram_wr_en=0, overflow=1 and stays set, count=16, wr_ptr unchanged.
- Pop 16 times -> pop_valid one cycle after each pop, pop_data 0x10..0x1F in order. empty=1 after the last pop. A further pop gives underflow=1 and ram_rd_en=0.
- Fill to 16, then push 0xAA with pop on the same cycle -> both accepted, count=16, popped data=0x10. 0xAA is later read at address 0 after the wrap.
- Empty FIFO with push 0x55 and pop on the same cycle -> count=1, underflow=1, no pop_valid. The next pop returns 0x55.
- Push 40 words with interleaved pops to force the pointers to wrap twice -> data order preserved and count matches the reference-model occupancy every cycle. Then assert reset mid-read -> pop_valid=0 and count=0 the next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the 16x8 FIFO controller and its pointer registers.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_SIZE  = 4;
    localparam int DEF_DEPTH      = 2 ** DEF_ADDR_SIZE;
    localparam int DEF_AF_LEVEL   = 14;
    localparam int DEF_AE_LEVEL   = 2;

    // One extra MSB is the wrap bit that tells full apart from empty.
    typedef logic [DEF_ADDR_SIZE:0] ptr_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: counts up on inc and rolls over naturally at 2**WIDTH.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int WIDTH = $bits(ptr_t)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] ptr
);

    localparam logic [WIDTH-1:0] PTR_ONE = 1;

    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + PTR_ONE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo_16x8_ctrl.sv
// FIFO controller driving an external 16x8 synchronous dual-port RAM with a registered read port.
module sync_fifo_16x8_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
    parameter int AF_LEVEL   = DEF_AF_LEVEL,
    parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_SIZE:0]    count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  ram_wr_en,
    output logic [ADDR_SIZE-1:0]  ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_d_in,
    output logic                  ram_rd_en,
    output logic [ADDR_SIZE-1:0]  ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_d_out
);

    localparam logic [ADDR_SIZE:0] CNT_ONE = 1;
    localparam logic [ADDR_SIZE:0] AF_CNT  = AF_LEVEL[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0] AE_CNT  = AE_LEVEL[ADDR_SIZE:0];

    logic [ADDR_SIZE:0] wr_ptr;
    logic [ADDR_SIZE:0] rd_ptr;
    logic               push_acc;
    logic               pop_acc;

    logic [ADDR_SIZE:0] count_q, count_d;
    logic               pop_valid_q, pop_valid_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    fifo_ptr #(.WIDTH(ADDR_SIZE + 1)) u_wr_ptr (
        .clock (clock),
        .reset (reset),
        .inc   (push_acc),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.WIDTH(ADDR_SIZE + 1)) u_rd_ptr (
        .clock (clock),
        .reset (reset),
        .inc   (pop_acc),
        .ptr   (rd_ptr)
    );

    // Flags decode from registered pointers only, so push/pop never reach them combinationally.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_SIZE] != rd_ptr[ADDR_SIZE]) &&
                   (wr_ptr[ADDR_SIZE-1:0] == rd_ptr[ADDR_SIZE-1:0]);

    // A push into a full FIFO is still taken when a pop frees the slot in the same cycle.
    assign pop_acc  = pop & ~empty;
    assign push_acc = push & (~full | pop_acc);

    // NOTE: every variable driven here gets a default first so no latch can be inferred.
    always_comb begin
        count_d     = count_q;
        pop_valid_d = pop_acc;
        overflow_d  = overflow_q | (push & ~push_acc);
        underflow_d = underflow_q | (pop & ~pop_acc);
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count        = count_q;
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign pop_valid    = pop_valid_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign ram_wr_en   = push_acc;
    assign ram_wr_addr = wr_ptr[ADDR_SIZE-1:0];
    assign ram_d_in    = push_data;
    assign ram_rd_en   = pop_acc;
    assign ram_rd_addr = rd_ptr[ADDR_SIZE-1:0];
    assign pop_data    = ram_d_out;

endmodule
